// File: rtl/fme_pkg.sv
// rtl/fme_pkg.sv - shared FME constants, scheduler state enum and address helper
package fme_pkg;
  localparam int FME_ROW_STRIDE = 16;
  localparam int FME_NUM_HALF   = 9;
  localparam int FME_HALF_W     = 8 * FME_NUM_HALF;
  localparam int FME_TIMEOUT    = 40;
  localparam int FME_DIM_W      = 3;

  // Half-pel position k occupies bits [8k+7:8k] of the result bus.
  localparam int HP_TL = 0;
  localparam int HP_T  = 1;
  localparam int HP_TR = 2;
  localparam int HP_L  = 3;
  localparam int HP_C  = 4;
  localparam int HP_R  = 5;
  localparam int HP_BL = 6;
  localparam int HP_B  = 7;
  localparam int HP_BR = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_EMIT   = 2'd3
  } sched_state_e;

  // 8-bit wrap-around window address; edge clamping is the caller's job.
  function automatic logic [7:0] fme_addr(input logic [7:0] base, input logic [7:0] row,
                                          input logic [7:0] col, input logic [7:0] stride);
    return base + row * stride + col;
  endfunction
endpackage

// File: rtl/fme_raster_cnt.sv
// rtl/fme_raster_cnt.sv - raster row/col counter over a job block with last flag
// addr_nxt is the address the counter will point at after this cycle's load/advance.
module fme_raster_cnt
  import fme_pkg::*;
#(
  parameter int DIM_W      = FME_DIM_W,
  parameter int ROW_STRIDE = FME_ROW_STRIDE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [7:0]       base_in,
  input  logic [DIM_W-1:0] w_in,
  input  logic [DIM_W-1:0] h_in,
  input  logic             adv,
  output logic             last,
  output logic [7:0]       addr_nxt
);
  logic [7:0]       base_q, base_d;
  logic [DIM_W-1:0] w_q, w_d, h_q, h_d;
  logic [DIM_W-1:0] row_q, row_d, col_q, col_d;

  always_comb begin
    base_d = base_q;
    w_d    = w_q;
    h_d    = h_q;
    row_d  = row_q;
    col_d  = col_q;
    if (load) begin
      base_d = base_in;
      w_d    = w_in;
      h_d    = h_in;
      row_d  = '0;
      col_d  = '0;
    end else if (adv) begin
      if (col_q == w_q) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  assign last     = (row_q == h_q) && (col_q == w_q);
  assign addr_nxt = fme_addr(base_d, 8'(row_d), 8'(col_d), 8'(ROW_STRIDE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      w_q    <= '0;
      h_q    <= '0;
      row_q  <= '0;
      col_q  <= '0;
    end else begin
      base_q <= base_d;
      w_q    <= w_d;
      h_q    <= h_d;
      row_q  <= row_d;
      col_q  <= col_d;
    end
  end
endmodule

// File: rtl/fme_half_sched.sv
// rtl/fme_half_sched.sv - half-pel interpolator sequencer: one restart per centre,
// then forwards the nine captured half-pel results on a valid/ready stream.
module fme_half_sched
  import fme_pkg::*;
#(
  parameter int ROW_STRIDE = FME_ROW_STRIDE,
  parameter int TIMEOUT    = FME_TIMEOUT,
  parameter int DIM_W      = FME_DIM_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [7:0]            job_base,
  input  logic [DIM_W-1:0]      job_w,
  input  logic [DIM_W-1:0]      job_h,
  output logic                  ip_start,
  output logic [7:0]            ip_center,
  input  logic                  ip_done,
  input  logic [FME_HALF_W-1:0] ip_half,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FME_HALF_W-1:0] out_half,
  output logic [7:0]            out_addr,
  output logic                  out_last,
  output logic                  busy,
  output logic                  err_timeout
);
  localparam int TW = $clog2(TIMEOUT + 1);

  sched_state_e          state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  ip_start_q, ip_start_d;
  logic [7:0]            ip_center_q, ip_center_d;
  logic                  out_valid_q, out_valid_d;
  logic [FME_HALF_W-1:0] out_half_q, out_half_d;
  logic [7:0]            out_addr_q, out_addr_d;
  logic                  out_last_q, out_last_d;
  logic                  err_q, err_d;
  logic                  cnt_load, cnt_adv, cnt_last;
  logic [7:0]            cnt_addr_nxt;

  fme_raster_cnt #(.DIM_W(DIM_W), .ROW_STRIDE(ROW_STRIDE)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .base_in  (job_base),
    .w_in     (job_w),
    .h_in     (job_h),
    .adv      (cnt_adv),
    .last     (cnt_last),
    .addr_nxt (cnt_addr_nxt)
  );

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    ip_center_d = ip_center_q;
    out_valid_d = out_valid_q;
    out_half_d  = out_half_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    err_d       = err_q;
    cnt_load    = 1'b0;
    cnt_adv     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (job_valid) begin
          cnt_load    = 1'b1;
          err_d       = 1'b0;
          ip_center_d = cnt_addr_nxt;
          state_d     = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // ip_done is a level from the previous centre until the restart lands.
        if (timer_q != '0 && ip_done) begin
          out_valid_d = 1'b1;
          out_half_d  = ip_half;
          out_addr_d  = ip_center_q;
          out_last_d  = cnt_last;
          state_d     = ST_EMIT;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = ST_IDLE;
          end else begin
            cnt_adv     = 1'b1;
            ip_center_d = cnt_addr_nxt;
            state_d     = ST_LAUNCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ip_start_d = (state_d == ST_LAUNCH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      ip_start_q  <= 1'b0;
      ip_center_q <= '0;
      out_valid_q <= 1'b0;
      out_half_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      ip_start_q  <= ip_start_d;
      ip_center_q <= ip_center_d;
      out_valid_q <= out_valid_d;
      out_half_q  <= out_half_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign job_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign ip_start    = ip_start_q;
  assign ip_center   = ip_center_q;
  assign out_valid   = out_valid_q;
  assign out_half    = out_half_q;
  assign out_addr    = out_addr_q;
  assign out_last    = out_last_q;
  assign err_timeout = err_q;
endmodule

// File: tb/tb_fme_half_sched.sv
// tb/tb_fme_half_sched.sv - scoreboard bench for fme_half_sched with a behavioural
// interpolator that holds ip_done stale for one cycle after each restart.
module tb_fme_half_sched;
  localparam int LAT = 26;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid;
  logic        job_ready;
  logic [7:0]  job_base;
  logic [2:0]  job_w, job_h;
  logic        ip_start;
  logic [7:0]  ip_center;
  logic        ip_done;
  logic [71:0] ip_half;
  logic        out_valid;
  logic        out_ready;
  logic [71:0] out_half;
  logic [7:0]  out_addr;
  logic        out_last;
  logic        busy;
  logic        err_timeout;

  int errors = 0;
  int checks = 0;
  int n_start = 0;
  int beats = 0;
  logic [7:0] m_center;
  int m_cnt = 0;
  bit m_run = 0;
  bit hang = 0;
  logic [80:0] exp_q[$];

  always #5 clk = ~clk;

  fme_half_sched dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_base(job_base), .job_w(job_w), .job_h(job_h), .ip_start(ip_start),
    .ip_center(ip_center), .ip_done(ip_done), .ip_half(ip_half),
    .out_valid(out_valid), .out_ready(out_ready), .out_half(out_half),
    .out_addr(out_addr), .out_last(out_last), .busy(busy), .err_timeout(err_timeout)
  );

  function automatic logic [71:0] hfun(input logic [7:0] a);
    logic [71:0] h;
    for (int k = 0; k < 9; k++) h[8*k +: 8] = a + 8'(k * 29) + 8'h05;
    return h;
  endfunction

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic last);
    exp_q.push_back({last, a, hfun(a)});
  endtask

  // Interpolator model: done rises LAT cycles after restart, stale level held one extra cycle.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      ip_done = 1'b0;
      m_run   = 0;
    end else if (ip_start) begin
      n_start++;
      m_center = ip_center;
      m_cnt    = 0;
      m_run    = 1;
    end else if (m_run) begin
      m_cnt++;
      if (m_cnt > 1) begin
        if (!hang && m_cnt >= LAT) begin
          if (!ip_done) ip_half = hfun(m_center);
          ip_done = 1'b1;
        end else begin
          ip_done = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      beats++;
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {64'd0, out_addr}, 72'hFFFF);
      end else begin
        logic [80:0] e;
        e = exp_q.pop_front();
        chk("beat_addr", 72'(out_addr), 72'(e[79:72]));
        chk("beat_half", out_half, e[71:0]);
        chk("beat_last", 72'(out_last), 72'(e[80]));
      end
    end
  end

  task automatic issue_job(input logic [7:0] b, input logic [2:0] w, input logic [2:0] h);
    int n = 0;
    while (!job_ready && n < 300) begin
      @(posedge clk); #1; n++;
    end
    chk("job_ready_wait", 72'(job_ready), 72'(1));
    job_base  = b;
    job_w     = w;
    job_h     = h;
    job_valid = 1'b1;
    @(posedge clk); #1;
    job_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 400) begin
      @(posedge clk); #1; n++;
    end
    chk("idle_wait", 72'(busy), 72'(0));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_job_ready"}, 72'(job_ready), 72'(1));
    chk({tag, "_busy"}, 72'(busy), 72'(0));
    chk({tag, "_ip_start"}, 72'(ip_start), 72'(0));
    chk({tag, "_ip_center"}, 72'(ip_center), 72'(0));
    chk({tag, "_out_valid"}, 72'(out_valid), 72'(0));
    chk({tag, "_out_half"}, out_half, 72'(0));
    chk({tag, "_out_addr"}, 72'(out_addr), 72'(0));
    chk({tag, "_out_last"}, 72'(out_last), 72'(0));
    chk({tag, "_err"}, 72'(err_timeout), 72'(0));
  endtask

  initial begin
    int n;
    int s0;
    logic [7:0]  h_addr;
    logic [71:0] h_half;
    rst = 1'b1; job_valid = 1'b0; job_base = '0; job_w = '0; job_h = '0;
    out_ready = 1'b1; ip_done = 1'b0; ip_half = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // 1x1 job
    n_start = 0;
    push(8'h44, 1'b1);
    issue_job(8'h44, 3'd0, 3'd0);
    wait_idle(n);
    chk("1x1_starts", 72'(n_start), 72'(1));
    chk("1x1_center", 72'(m_center), 72'h44);
    chk("1x1_job_ready", 72'(job_ready), 72'(1));
    chk("1x1_drained", 72'(exp_q.size()), 72'(0));

    // 2x2 raster
    n_start = 0;
    push(8'h20, 1'b0); push(8'h21, 1'b0); push(8'h30, 1'b0); push(8'h31, 1'b1);
    issue_job(8'h20, 3'd1, 3'd1);
    wait_idle(n);
    chk("2x2_starts", 72'(n_start), 72'(4));
    chk("2x2_drained", 72'(exp_q.size()), 72'(0));

    // Backpressure: hold out_ready low for 5 cycles on the first beat
    n_start = 0;
    out_ready = 1'b0;
    push(8'h50, 1'b0); push(8'h51, 1'b1);
    issue_job(8'h50, 3'd1, 3'd0);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("bp_valid_seen", 72'(out_valid), 72'(1));
    h_addr = out_addr;
    h_half = out_half;
    s0 = n_start;
    chk("bp_addr", 72'(h_addr), 72'h50);
    repeat (5) begin
      @(negedge clk);
      chk("bp_addr_stable", 72'(out_addr), 72'(h_addr));
      chk("bp_half_stable", out_half, h_half);
      chk("bp_no_start", 72'(ip_start), 72'(0));
    end
    chk("bp_start_count", 72'(n_start), 72'(s0));
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle(n);
    chk("bp_starts", 72'(n_start), 72'(2));
    chk("bp_drained", 72'(exp_q.size()), 72'(0));

    // Address wrap
    push(8'hF8, 1'b0); push(8'h08, 1'b1);
    issue_job(8'hF8, 3'd0, 3'd1);
    wait_idle(n);
    chk("wrap_drained", 72'(exp_q.size()), 72'(0));

    // Timeout: interpolator never finishes
    hang = 1;
    s0 = beats;
    issue_job(8'h10, 3'd0, 3'd0);
    wait_idle(n);
    chk("to_err", 72'(err_timeout), 72'(1));
    chk("to_len_ok", 72'(n >= 40 && n <= 42), 72'(1));
    chk("to_no_beats", 72'(beats - s0), 72'(0));
    hang = 0;
    push(8'h77, 1'b1);
    issue_job(8'h77, 3'd0, 3'd0);
    chk("to_err_cleared", 72'(err_timeout), 72'(0));
    wait_idle(n);
    chk("to_next_drained", 72'(exp_q.size()), 72'(0));

    // Reset while waiting on the interpolator
    n_start = 0;
    issue_job(8'h60, 3'd1, 3'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("rst_in_wait_busy", 72'(busy), 72'(1));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst_mid");
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;

    push(8'h12, 1'b1);
    issue_job(8'h12, 3'd0, 3'd0);
    wait_idle(n);
    chk("post_rst_drained", 72'(exp_q.size()), 72'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
